dcache_ctrl: RTL and testbench
==============================

Name: dcache_ctrl

Overview:
- Direct-mapped, write-back, write-allocate data cache between the pipeline memory stage and the backing data memory.
- Replaces the direct data-memory path. Produces the Done/Stall/CacheHit signals that the processor bench counts as data-cache requests and hits.
- The pipeline holds Addr/DataIn/Rd/Wr stable while Stall=1.
- Tag, valid, dirty and data arrays are internal flops.

Parameters:
- IDX_BITS, 5, index width; number of lines = 2^IDX_BITS.
- LINE_WORDS, 4, 16-bit words per line; fixed at 4, offset = Addr[2:0].

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- Addr  in  16  byte address; [2:1] word in line, [2+IDX_BITS:3] index, rest tag
- DataIn  in  16  store data
- Rd  in  1  load request
- Wr  in  1  store request
- DataOut  out  16  load data, valid when Done=1 and the request was a load
- Done  out  1  access complete this cycle
- Stall  out  1  pipeline must hold the memory stage
- CacheHit  out  1  access completed as a hit (asserted together with Done)
- err  out  1  illegal request
- mem_req  out  1  backing-memory word request
- mem_we  out  1  1 = write-back word, 0 = fill word
- mem_addr  out  16  word-aligned backing address
- mem_wdata  out  16  write-back data
- mem_rdata  in  16  fill data, valid with mem_ack
- mem_ack  in  1  one word transferred this cycle

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE, word counter=0.
  - All valid and dirty bits cleared in one cycle; tags and data are don't-care.
  - All outputs 0.
  - Reset during WB or ALLOC abandons the transfer: mem_req drops on the next cycle and no array is updated by the aborted transfer.
- err:
  - Asserted combinationally in IDLE when Rd&Wr, or when (Rd|Wr)&Addr[0].
  - No array update, no state change, Done=0, Stall=0.
- States: IDLE, WB, ALLOC, RETRY.
- IDLE, Rd^Wr with no error:
  - hit = valid[idx] & (tag[idx]==Addr tag).
  - On a hit: Done=1, CacheHit=1, Stall=0 in the same cycle. DataOut is driven from the array (asynchronous read). A store writes its word and sets dirty at the clock edge.
  - On a miss: Stall=1 this cycle. Next state is WB if valid&dirty, else ALLOC. Word counter is cleared.
- WB:
  - mem_req=1, mem_we=1.
  - mem_addr = {old tag, idx, cnt, 1'b0}; mem_wdata = line word[cnt].
  - Each mem_ack advances cnt; the ack on cnt=3 leads to ALLOC with cnt=0.
- ALLOC:
  - mem_req=1, mem_we=0.
  - mem_addr = {new tag, idx, cnt, 1'b0}.
  - Each mem_ack writes mem_rdata into word[cnt]; the ack on cnt=3 writes tag, sets valid=1, clears dirty, and goes to RETRY.
- mem_req is held with unchanged address and data until mem_ack. Any number of wait cycles is legal.
- RETRY:
  - Done=1, CacheHit=0, Stall=0.
  - A load drives DataOut from the filled line. A store merges DataIn into its word and sets dirty.
  - Next state is IDLE.
- Stall=1 in WB and ALLOC, and in IDLE on a miss; 0 otherwise.
- Done and CacheHit are never asserted together with Stall.
- Latency with mem_ack every cycle:
  - hit: 0 extra cycles.
  - clean miss: Done at cycle 5 after the request.
  - dirty miss: Done at cycle 9 after the request.
- Rd=Wr=0 in IDLE: no action, all outputs 0 (DataOut don't-care).
- Stray mem_ack in IDLE or RETRY is ignored.
- The counter wraps from 3 to 0 only via a state change.

Test Plan:
1. After reset, Rd Addr=0x0010 → miss, Stall=1. ALLOC reads 0x0010, 0x0012, 0x0014, 0x0016 with an ack each cycle. At cycle 5 Done=1, CacheHit=0, DataOut = word 0 of the fill.
2. Repeat Rd Addr=0x0014 → same-cycle Done=1, CacheHit=1, DataOut = fill word 2, mem_req stays 0.
3. Wr 0x0012 with 0xBEEF (hit, line becomes dirty), then Rd 0x0112 (same index, new tag):
   - WB writes 4 words to 0x0010..0x0016, with 0xBEEF at 0x0012.
   - ALLOC then fetches 0x0110..0x0116.
   - Done at cycle 9.
4. Rd=Wr=1 → err=1, no state change. Rd Addr=0x0021 → err=1, Stall=0, Done=0.
5. Clean miss with mem_ack delayed 3 cycles per word → mem_req and mem_addr held stable each wait; Done at cycle 17; Stall continuous until Done.
6. Assert rst mid-ALLOC (cnt=2) → next cycle state IDLE, mem_req=0. Re-read of the same address misses (valid cleared).

Source files
------------

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache sitting between the
// pipeline memory stage and a word-wide backing memory.
module dcache_ctrl #(
   parameter int IDX_BITS   = 5,
   parameter int LINE_WORDS = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] Addr,
   input  logic [15:0] DataIn,
   input  logic        Rd,
   input  logic        Wr,
   output logic [15:0] DataOut,
   output logic        Done,
   output logic        Stall,
   output logic        CacheHit,
   output logic        err,
   output logic        mem_req,
   output logic        mem_we,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   input  logic [15:0] mem_rdata,
   input  logic        mem_ack,
   output logic [1:0]  dbg_state_o
);

   localparam int TAG_W  = 16 - 3 - IDX_BITS;
   localparam int NLINES = 1 << IDX_BITS;

   typedef enum logic [1:0] {IDLE, WB, ALLOC, RETRY} state_t;

   state_t     state_q, state_d;
   logic [1:0] cnt_q, cnt_d;

   logic [TAG_W-1:0] tag_q [NLINES];
   logic [NLINES-1:0] valid_q, dirty_q;
   logic [15:0]      data_q [NLINES][LINE_WORDS];

   logic [IDX_BITS-1:0] idx;
   logic [TAG_W-1:0]    tag_in;
   logic [1:0]          word;
   logic                hit, bad_req;

   logic        done_c, stall_c, hit_c, err_c, req_c, we_c;
   logic [15:0] maddr_c, mwdata_c, dout_c;
   logic        data_we, set_dirty, fill_done;
   logic [1:0]  data_word;
   logic [15:0] data_wval;

   assign idx     = Addr[2+IDX_BITS:3];
   assign tag_in  = Addr[15:3+IDX_BITS];
   assign word    = Addr[2:1];
   assign hit     = valid_q[idx] & (tag_q[idx] == tag_in);
   assign bad_req = (Rd & Wr) | ((Rd | Wr) & Addr[0]);

   // Addr/DataIn/Rd/Wr are held by the pipeline while stalled, so the
   // victim and fill line are always addressed from the live request.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      done_c    = 1'b0;
      stall_c   = 1'b0;
      hit_c     = 1'b0;
      err_c     = 1'b0;
      req_c     = 1'b0;
      we_c      = 1'b0;
      maddr_c   = 16'h0;
      mwdata_c  = 16'h0;
      dout_c    = 16'h0;
      data_we   = 1'b0;
      set_dirty = 1'b0;
      fill_done = 1'b0;
      data_word = word;
      data_wval = DataIn;
      case (state_q)
         IDLE: begin
            if (bad_req) begin
               err_c = 1'b1;
            end else if (Rd | Wr) begin
               if (hit) begin
                  done_c = 1'b1;
                  hit_c  = 1'b1;
                  dout_c = data_q[idx][word];
                  if (Wr) begin
                     data_we   = 1'b1;
                     set_dirty = 1'b1;
                  end
               end else begin
                  stall_c = 1'b1;
                  cnt_d   = 2'd0;
                  state_d = (valid_q[idx] & dirty_q[idx]) ? WB : ALLOC;
               end
            end
         end
         WB: begin
            req_c    = 1'b1;
            we_c     = 1'b1;
            stall_c  = 1'b1;
            maddr_c  = {tag_q[idx], idx, cnt_q, 1'b0};
            mwdata_c = data_q[idx][cnt_q];
            if (mem_ack) begin
               cnt_d = (cnt_q == 2'd3) ? 2'd0 : cnt_q + 2'd1;
               if (cnt_q == 2'd3) state_d = ALLOC;
            end
         end
         ALLOC: begin
            req_c   = 1'b1;
            stall_c = 1'b1;
            maddr_c = {tag_in, idx, cnt_q, 1'b0};
            if (mem_ack) begin
               data_we   = 1'b1;
               data_word = cnt_q;
               data_wval = mem_rdata;
               cnt_d     = (cnt_q == 2'd3) ? 2'd0 : cnt_q + 2'd1;
               if (cnt_q == 2'd3) begin
                  fill_done = 1'b1;
                  state_d   = RETRY;
               end
            end
         end
         RETRY: begin
            done_c  = 1'b1;
            dout_c  = data_q[idx][word];
            state_d = IDLE;
            if (Wr) begin
               data_we   = 1'b1;
               set_dirty = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= 2'd0;
         valid_q <= '0;
         dirty_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (fill_done) begin
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= 1'b0;
         end
         if (set_dirty) dirty_q[idx] <= 1'b1;
      end
   end

   // Tags and data carry no reset; reset only blocks the write enables.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (data_we)   data_q[idx][data_word] <= data_wval;
         if (fill_done) tag_q[idx] <= tag_in;
      end
   end

   assign Done        = done_c  & ~rst;
   assign Stall       = stall_c & ~rst;
   assign CacheHit    = hit_c   & ~rst;
   assign err         = err_c   & ~rst;
   assign mem_req     = req_c   & ~rst;
   assign mem_we      = we_c    & ~rst;
   assign mem_addr    = rst ? 16'h0 : maddr_c;
   assign mem_wdata   = rst ? 16'h0 : mwdata_c;
   assign DataOut     = rst ? 16'h0 : dout_c;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_dcache_ctrl.sv
// Randomized bench for dcache_ctrl: a line-level cache model plus a backing
// memory model predict hit/miss, latency, load data and memory traffic.
module tb_dcache_ctrl;

   localparam int W = 33;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] Addr, DataIn, DataOut, mem_addr, mem_wdata, mem_rdata;
   logic        Rd, Wr, Done, Stall, CacheHit, err, mem_req, mem_we, mem_ack;
   logic [1:0]  dbg_state;

   int total = 0;
   int bad   = 0;
   int resp_delay = 0;
   bit stray_en = 0;

   logic [W-1:0] exp_q[$];
   logic [W-1:0] obs_q[$];

   logic [7:0]  m_tag   [32];
   bit          m_valid [32];
   bit          m_dirty [32];
   logic [15:0] m_line  [32][4];
   logic [15:0] bmem [logic [15:0]];

   dcache_ctrl dut (
      .clk(clk), .rst(rst), .Addr(Addr), .DataIn(DataIn), .Rd(Rd), .Wr(Wr),
      .DataOut(DataOut), .Done(Done), .Stall(Stall), .CacheHit(CacheHit),
      .err(err), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .dbg_state_o(dbg_state)
   );

   // clock / reset
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] mem_rd(input logic [15:0] a);
      if (bmem.exists(a)) return bmem[a];
      return (a * 16'd40503) ^ 16'h5A3C;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 32; i++) begin
         m_valid[i] = 0;
         m_dirty[i] = 0;
      end
   endtask

   // backing memory responder: acts just after each rising edge
   initial begin
      int          waited;
      bit          holding;
      logic [15:0] held_addr, held_wdata;
      logic        held_we;
      waited = 0; holding = 0; held_addr = 0; held_wdata = 0; held_we = 0;
      mem_ack = 1'b0;
      mem_rdata = 16'h0;
      forever begin
         @(posedge clk); #1;
         if (rst) begin
            waited = 0; holding = 0; mem_ack = 1'b0;
            continue;
         end
         if (mem_req) begin
            if (holding) begin
               check("hold_addr", mem_addr, held_addr);
               check("hold_we", mem_we, held_we);
               if (held_we) check("hold_wdata", mem_wdata, held_wdata);
            end
            if (waited < resp_delay) begin
               waited++;
               mem_ack = 1'b0;
               holding = 1;
               held_addr = mem_addr; held_we = mem_we; held_wdata = mem_wdata;
            end else begin
               waited = 0;
               holding = 0;
               mem_ack = 1'b1;
               if (mem_we) begin
                  obs_q.push_back({1'b1, mem_addr, mem_wdata});
               end else begin
                  mem_rdata = mem_rd(mem_addr);
                  obs_q.push_back({1'b0, mem_addr, mem_rdata});
               end
            end
         end else begin
            waited = 0;
            holding = 0;
            mem_ack = stray_en && ($urandom_range(0, 3) == 0);
            mem_rdata = 16'($urandom);
         end
      end
   end

   // driver: one pipeline access, checked against the model
   task automatic do_access(input logic rd, input logic wr, input logic [15:0] addr,
                            input logic [15:0] wdata, input int dly);
      int          i, w, cyc, exp_lat;
      logic [7:0]  t;
      logic [15:0] a, exp_dout;
      bit          exp_hit, is_err, got_done;
      i = int'(addr[7:3]);
      t = addr[15:8];
      w = int'(addr[2:1]);
      is_err = (rd & wr) | ((rd | wr) & addr[0]);
      resp_delay = dly;
      @(negedge clk);
      Rd = rd; Wr = wr; Addr = addr; DataIn = wdata;
      #1;
      if (is_err) begin
         check("err_flag", err, 1);
         check("err_done", Done, 0);
         check("err_stall", Stall, 0);
         check("err_memreq", mem_req, 0);
         @(negedge clk);
         Rd = 0; Wr = 0;
         #1;
         check("err_after_stall", Stall, 0);
         check("err_after_memreq", mem_req, 0);
         return;
      end
      exp_hit = m_valid[i] && (m_tag[i] == t);
      exp_lat = 0;
      if (!exp_hit) begin
         exp_lat = 1 + 4 * (dly + 1);
         if (m_valid[i] && m_dirty[i]) begin
            exp_lat += 4 * (dly + 1);
            for (int k = 0; k < 4; k++) begin
               a = {m_tag[i], i[4:0], k[1:0], 1'b0};
               exp_q.push_back({1'b1, a, m_line[i][k]});
               bmem[a] = m_line[i][k];
            end
         end
         for (int k = 0; k < 4; k++) begin
            a = {t, i[4:0], k[1:0], 1'b0};
            m_line[i][k] = mem_rd(a);
            exp_q.push_back({1'b0, a, m_line[i][k]});
         end
         m_valid[i] = 1; m_tag[i] = t; m_dirty[i] = 0;
      end
      exp_dout = m_line[i][w];
      if (wr) begin
         m_line[i][w] = wdata;
         m_dirty[i] = 1;
      end
      cyc = 0;
      got_done = 0;
      while (cyc <= 300) begin
         if (Done) begin
            got_done = 1;
            break;
         end
         check("stall_while_busy", Stall, 1);
         @(negedge clk); #1;
         cyc++;
      end
      check("done_seen", got_done, 1);
      if (got_done) begin
         check("latency", cyc, exp_lat);
         check("cachehit", CacheHit, exp_hit);
         check("stall_at_done", Stall, 0);
         check("err_at_done", err, 0);
         if (exp_hit) check("memreq_on_hit", mem_req, 0);
         if (rd) check("dataout", DataOut, exp_dout);
      end
      check("mem_ops", obs_q.size(), exp_q.size());
      while (obs_q.size() > 0 && exp_q.size() > 0)
         check("mem_op", obs_q.pop_front(), exp_q.pop_front());
      obs_q.delete();
      exp_q.delete();
   endtask

   initial begin
      #2000000;
      bad++;
      $display("FAIL watchdog timeout");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      logic [7:0]  tags [4];
      int          idxs [4];
      logic [15:0] ra;
      logic        rrd, rwr;
      tags[0] = 8'h00; tags[1] = 8'h01; tags[2] = 8'h02; tags[3] = 8'h7F;
      idxs[0] = 0; idxs[1] = 2; idxs[2] = 5; idxs[3] = 31;
      rst = 1; Rd = 0; Wr = 0; Addr = 0; DataIn = 0;
      model_clear();
      repeat (2) @(negedge clk);
      #1;
      check("rst_done", Done, 0);
      check("rst_stall", Stall, 0);
      check("rst_err", err, 0);
      check("rst_memreq", mem_req, 0);
      check("rst_hit", CacheHit, 0);
      @(negedge clk);
      rst = 0;
      #1;
      check("idle_memreq", mem_req, 0);
      check("idle_stall", Stall, 0);

      // clean miss, hit, dirty victim eviction
      do_access(1, 0, 16'h0010, 16'h0, 0);
      do_access(1, 0, 16'h0014, 16'h0, 0);
      do_access(0, 1, 16'h0012, 16'hBEEF, 0);
      do_access(1, 0, 16'h0112, 16'h0, 0);

      // illegal requests leave everything untouched
      do_access(1, 1, 16'h0112, 16'h1111, 0);
      do_access(1, 0, 16'h0021, 16'h0, 0);
      do_access(1, 0, 16'h0112, 16'h0, 0);

      // slow memory
      do_access(1, 0, 16'h0220, 16'h0, 3);

      // reset in the middle of a fill
      resp_delay = 0;
      @(negedge clk);
      Rd = 1; Wr = 0; Addr = 16'h0330;
      repeat (3) @(negedge clk);
      #1;
      check("abort_pre_req", mem_req, 1);
      check("abort_pre_addr", mem_addr, 16'h0334);
      rst = 1;
      @(negedge clk); #1;
      check("abort_memreq", mem_req, 0);
      check("abort_stall", Stall, 0);
      check("abort_done", Done, 0);
      rst = 0; Rd = 0;
      @(negedge clk); #1;
      check("post_abort_memreq", mem_req, 0);
      check("post_abort_stall", Stall, 0);
      check("post_abort_err", err, 0);
      obs_q.delete();
      exp_q.delete();
      model_clear();
      do_access(1, 0, 16'h0330, 16'h0, 0);
      do_access(1, 0, 16'h0014, 16'h0, 0);

      // random traffic with stray acks in idle
      stray_en = 1;
      for (int n = 0; n < 200; n++) begin
         ra = {tags[$urandom_range(0, 3)], 5'(idxs[$urandom_range(0, 3)]),
               2'($urandom_range(0, 3)), 1'b0};
         rrd = $urandom_range(0, 1);
         rwr = ~rrd;
         case ($urandom_range(0, 15))
            0: ra[0] = 1'b1;
            1: begin rrd = 1; rwr = 1; end
            default: ;
         endcase
         do_access(rrd, rwr, ra, 16'($urandom), $urandom_range(0, 2));
      end
      stray_en = 0;
      @(negedge clk);
      Rd = 0; Wr = 0;
      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
